// File: rtl/pipe_stage_skid_reg.sv
// Inter-stage pipeline register with valid/ready handshake, one-entry skid buffer and flush.
// Optional PIPE_STAGE_STATS_EN macro adds saturating stall/bubble counters.
module pipe_stage_skid_reg #(
  parameter int DATA_W = 64,
  parameter int CTRL_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl
`ifdef PIPE_STAGE_STATS_EN
  ,
  output logic [31:0]       stall_cnt,
  output logic [31:0]       bubble_cnt
`endif
);

  // Bit 0 is main_v and bit 1 is skid_v; 2'b10 (skid without main) is unreachable.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    FULL  = 2'b11
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic              main_v;
  logic              skid_v;
  logic [DATA_W-1:0] main_d;
  logic [CTRL_W-1:0] main_c;
  logic [DATA_W-1:0] skid_d;
  logic [CTRL_W-1:0] skid_c;
  logic              in_fire;
  logic              out_fire;
  logic              ld_main_in;
  logic              ld_main_skid;
  logic              ld_skid;

  assign main_v   = state[0];
  assign skid_v   = state[1];
  assign in_ready = ~skid_v;
  assign in_fire  = in_valid & in_ready;
  assign out_fire = main_v & out_ready;

  assign out_valid = main_v;
  assign out_data  = main_d;
  assign out_ctrl  = main_c & {CTRL_W{main_v}};

  // Occupancy state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= EMPTY;
    end else begin
      state <= state_nxt;
    end
  end

  // Next occupancy and payload load selects; flush overrides everything
  always_comb begin
    state_nxt    = state;
    ld_main_in   = 1'b0;
    ld_main_skid = 1'b0;
    ld_skid      = 1'b0;
    if (flush) begin
      state_nxt = EMPTY;
    end else begin
      case (state)
        EMPTY: begin
          if (in_fire) begin
            state_nxt  = ONE;
            ld_main_in = 1'b1;
          end else begin
            state_nxt = EMPTY;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            state_nxt  = ONE;
            ld_main_in = 1'b1;
          end else if (in_fire) begin
            state_nxt = FULL;
            ld_skid   = 1'b1;
          end else if (out_fire) begin
            state_nxt = EMPTY;
          end else begin
            state_nxt = ONE;
          end
        end
        FULL: begin
          if (out_fire) begin
            state_nxt    = ONE;
            ld_main_skid = 1'b1;
          end else begin
            state_nxt = FULL;
          end
        end
        default: begin
          state_nxt = EMPTY;
        end
      endcase
    end
  end

  // Payload registers; data survives a flush, control is squashed
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      main_d <= {DATA_W{1'b0}};
      main_c <= {CTRL_W{1'b0}};
      skid_d <= {DATA_W{1'b0}};
      skid_c <= {CTRL_W{1'b0}};
    end else if (flush) begin
      main_c <= {CTRL_W{1'b0}};
      skid_c <= {CTRL_W{1'b0}};
    end else begin
      if (ld_main_in) begin
        main_d <= in_data;
        main_c <= in_ctrl;
      end else if (ld_main_skid) begin
        main_d <= skid_d;
        main_c <= skid_c;
      end else begin
        main_d <= main_d;
        main_c <= main_c;
      end
      if (ld_skid) begin
        skid_d <= in_data;
        skid_c <= in_ctrl;
      end else begin
        skid_d <= skid_d;
        skid_c <= skid_c;
      end
    end
  end

`ifdef PIPE_STAGE_STATS_EN
  // Saturating stall and bubble counters, cleared only by reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt  <= 32'd0;
      bubble_cnt <= 32'd0;
    end else begin
      if (main_v && !out_ready && (stall_cnt != 32'hFFFF_FFFF)) begin
        stall_cnt <= stall_cnt + 32'd1;
      end else begin
        stall_cnt <= stall_cnt;
      end
      if (!main_v && (bubble_cnt != 32'hFFFF_FFFF)) begin
        bubble_cnt <= bubble_cnt + 32'd1;
      end else begin
        bubble_cnt <= bubble_cnt;
      end
    end
  end
`endif

endmodule

// File: tb/tb_pipe_stage_skid_reg.sv
// Self-checking bench for pipe_stage_skid_reg: directed vector table, corner sequences, random scoreboard.
module tb_pipe_stage_skid_reg;
  localparam int DW = 64;
  localparam int CW = 8;

  logic          clk;
  logic          rst;
  logic          flush;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic [CW-1:0] in_ctrl;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_data;
  logic [CW-1:0] out_ctrl;
`ifdef PIPE_STAGE_STATS_EN
  logic [31:0]   stall_cnt;
  logic [31:0]   bubble_cnt;
`endif

  pipe_stage_skid_reg #(.DATA_W(DW), .CTRL_W(CW)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_ctrl(in_ctrl),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ctrl(out_ctrl)
`ifdef PIPE_STAGE_STATS_EN
    , .stall_cnt(stall_cnt), .bubble_cnt(bubble_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic          iv;
    logic [DW-1:0] d;
    logic [CW-1:0] c;
    logic          ordy;
    logic          fl;
    logic          ev;
    logic [DW-1:0] ed;
    logic [CW-1:0] ec;
    logic          eir;
  } vec_t;

  typedef struct {
    logic [DW-1:0] d;
    logic [CW-1:0] c;
  } ent_t;

  vec_t vecs[$];
  ent_t q[$];
  int   n_pass = 0;
  int   n_total = 0;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
  endtask

  function automatic vec_t mk(input logic iv, input logic [DW-1:0] d, input logic [CW-1:0] c,
                              input logic ordy, input logic fl, input logic ev,
                              input logic [DW-1:0] ed, input logic [CW-1:0] ec, input logic eir);
    vec_t v;
    v.iv = iv; v.d = d; v.c = c; v.ordy = ordy; v.fl = fl;
    v.ev = ev; v.ed = ed; v.ec = ec; v.eir = eir;
    return v;
  endfunction

  task automatic check_out(input string tag, input logic ev, input logic [DW-1:0] ed,
                           input logic [CW-1:0] ec, input logic eir);
    chk({tag, "_out_valid"}, 64'(out_valid), 64'(ev));
    chk({tag, "_out_data"}, 64'(out_data), 64'(ed));
    chk({tag, "_out_ctrl"}, 64'(out_ctrl), 64'(ec));
    chk({tag, "_in_ready"}, 64'(in_ready), 64'(eir));
  endtask

  logic          r_iv;
  logic [DW-1:0] r_d;
  logic [CW-1:0] r_c;
  logic          r_or;
  logic          r_fl;
  logic          in_f;
  logic          out_f;
  ent_t          e;

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; in_data = '0; in_ctrl = '0; out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_out("reset", 1'b0, 64'd0, 8'h00, 1'b1);
    rst = 1'b0;

    // streaming 1..8 with zero bubbles
    for (int k = 1; k <= 8; k++)
      vecs.push_back(mk(1'b1, 64'(k), 8'hA5, 1'b1, 1'b0, 1'b1, 64'(k), 8'hA5, 1'b1));
    vecs.push_back(mk(1'b0, 64'd0, 8'h00, 1'b1, 1'b0, 1'b0, 64'd8, 8'h00, 1'b1));
    // backpressure into skid, then drain in order
    vecs.push_back(mk(1'b1, 64'd1, 8'h11, 1'b1, 1'b0, 1'b1, 64'd1, 8'h11, 1'b1));
    vecs.push_back(mk(1'b1, 64'd2, 8'h22, 1'b0, 1'b0, 1'b1, 64'd1, 8'h11, 1'b0));
    vecs.push_back(mk(1'b1, 64'd3, 8'h33, 1'b0, 1'b0, 1'b1, 64'd1, 8'h11, 1'b0));
    vecs.push_back(mk(1'b1, 64'd3, 8'h33, 1'b1, 1'b0, 1'b1, 64'd2, 8'h22, 1'b1));
    vecs.push_back(mk(1'b1, 64'd3, 8'h33, 1'b1, 1'b0, 1'b1, 64'd3, 8'h33, 1'b1));
    vecs.push_back(mk(1'b0, 64'd0, 8'h00, 1'b1, 1'b0, 1'b0, 64'd3, 8'h00, 1'b1));
    // flush while FULL with a concurrent input beat
    vecs.push_back(mk(1'b1, 64'd5, 8'hFF, 1'b0, 1'b0, 1'b1, 64'd5, 8'hFF, 1'b1));
    vecs.push_back(mk(1'b1, 64'd6, 8'h66, 1'b0, 1'b0, 1'b1, 64'd5, 8'hFF, 1'b0));
    vecs.push_back(mk(1'b1, 64'd7, 8'h77, 1'b0, 1'b1, 1'b0, 64'd5, 8'h00, 1'b1));
    vecs.push_back(mk(1'b0, 64'd0, 8'h00, 1'b1, 1'b0, 1'b0, 64'd5, 8'h00, 1'b1));
    // flush in ONE with simultaneous out_fire
    vecs.push_back(mk(1'b1, 64'd9, 8'h99, 1'b0, 1'b0, 1'b1, 64'd9, 8'h99, 1'b1));
    vecs.push_back(mk(1'b0, 64'd0, 8'h00, 1'b1, 1'b1, 1'b0, 64'd9, 8'h00, 1'b1));
    vecs.push_back(mk(1'b0, 64'd0, 8'h00, 1'b1, 1'b0, 1'b0, 64'd9, 8'h00, 1'b1));

    foreach (vecs[i]) begin
      in_valid = vecs[i].iv; in_data = vecs[i].d; in_ctrl = vecs[i].c;
      out_ready = vecs[i].ordy; flush = vecs[i].fl;
      @(posedge clk);
      #1;
      check_out($sformatf("vec%0d", i), vecs[i].ev, vecs[i].ed, vecs[i].ec, vecs[i].eir);
    end
    flush = 1'b0;

    // asynchronous reset while FULL
    in_valid = 1'b1; in_data = 64'hAA; in_ctrl = 8'h0A; out_ready = 1'b0;
    @(posedge clk); #1;
    in_data = 64'hBB; in_ctrl = 8'h0B;
    @(posedge clk); #1;
    chk("full_before_rst_in_ready", 64'(in_ready), 64'd0);
    #1;
    rst = 1'b1; in_valid = 1'b0;
    #1;
    check_out("async_rst", 1'b0, 64'd0, 8'h00, 1'b1);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(posedge clk); #1;
      chk("idle_after_rst_out_valid", 64'(out_valid), 64'd0);
    end
`ifdef PIPE_STAGE_STATS_EN
    chk("bubble_cnt_after_rst", 64'(bubble_cnt), 64'd3);
`endif

    // in_ready must not follow out_ready within a cycle
    in_valid = 1'b1; in_data = 64'h10; in_ctrl = 8'h01; out_ready = 1'b0;
    @(posedge clk); #1;
    in_data = 64'h11;
    @(posedge clk); #1;
    out_ready = 1'b1; #1;
    chk("full_in_ready_or1", 64'(in_ready), 64'd0);
    out_ready = 1'b0; #1;
    chk("full_in_ready_or0", 64'(in_ready), 64'd0);
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    chk("one_after_drain_data", 64'(out_data), 64'h11);
    out_ready = 1'b0; #1;
    chk("one_in_ready_or0", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("drained_out_valid", 64'(out_valid), 64'd0);

    // random valid/ready/flush against a queue model
    r_iv = 1'b0; r_d = '0; r_c = '0;
    for (int cyc = 0; cyc < 10000; cyc++) begin
      if (!(r_iv && !in_ready)) begin
        r_iv = 1'($urandom_range(0, 1));
        r_d = {$urandom, $urandom};
        r_c = 8'($urandom_range(0, 255));
      end
      r_or = ($urandom_range(0, 3) != 0) ^ (cyc[9] & ($urandom_range(0, 1) == 1));
      r_fl = ($urandom_range(0, 63) == 0);
      in_valid = r_iv; in_data = r_d; in_ctrl = r_c; out_ready = r_or; flush = r_fl;
      #1;
      chk("rnd_out_valid", 64'(out_valid), 64'(q.size() > 0));
      chk("rnd_in_ready", 64'(in_ready), 64'(q.size() < 2));
      chk("rnd_illegal_state", 64'(dut.skid_v & ~dut.main_v), 64'd0);
      if (q.size() > 0) begin
        chk("rnd_out_data", out_data, q[0].d);
        chk("rnd_out_ctrl", 64'(out_ctrl), 64'(q[0].c));
      end else begin
        chk("rnd_out_ctrl_idle", 64'(out_ctrl), 64'd0);
      end
      in_f = r_iv && (q.size() < 2);
      out_f = (q.size() > 0) && r_or;
      @(posedge clk); #1;
      if (out_f) void'(q.pop_front());
      if (r_fl) q.delete();
      else if (in_f) begin
        e.d = r_d; e.c = r_c;
        q.push_back(e);
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule

// File: doc/pipe_stage_skid_reg.md
Name: pipe_stage_skid_reg

Overview:
Generic inter-stage pipeline register for the static pipeline CPU. It replaces the fixed IF/ID, ID/EX, EX/MEM and MEM/WB registers.
- Parametrised payload: wide data field plus a separate control field (write enables, source selects).
- Adds a valid/ready handshake with a one-entry skid buffer, so backpressure from a stalled downstream stage never drops an instruction.
- Adds a synchronous flush that squashes in-flight entries into bubbles.

Parameters:
DATA_W, 64, width of data payload (operands, results, pc4, etc.); never cleared except by reset
CTRL_W, 8, width of control payload (write enables, mux selects); zeroed on flush and masked when not valid

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
flush  in  1  synchronous squash of all held entries and of the current input beat
in_valid  in  1  upstream presents an entry
in_ready  out  1  stage can accept an entry this cycle
in_data  in  DATA_W  upstream data payload
in_ctrl  in  CTRL_W  upstream control payload
out_valid  out  1  entry available to downstream stage
out_ready  in  1  downstream accepts entry this cycle
out_data  out  DATA_W  data of head entry
out_ctrl  out  CTRL_W  control of head entry, forced 0 when out_valid=0

Behaviour:
- Storage:
  - main register (main_v, main_d, main_c) drives the outputs.
  - skid register (skid_v, skid_d, skid_c) holds the overflow entry.
- in_ready = ~skid_v. It is registered-derived, with no combinational path from out_ready.
- out_valid = main_v; out_data = main_d; out_ctrl = main_c & {CTRL_W{main_v}}.
- Handshake events: in_fire = in_valid & in_ready; out_fire = main_v & out_ready.
- in_data/in_ctrl must be held stable by upstream while in_valid=1 and in_ready=0. out_data/out_ctrl stay stable while out_valid=1 and out_ready=0.
- States: EMPTY (main_v=0, skid_v=0), ONE (main_v=1, skid_v=0), FULL (both 1). skid_v=1 with main_v=0 is illegal and must never occur.
- EMPTY:
  - in_fire -> ONE, main<=in.
  - otherwise stay EMPTY. out_fire is impossible in this state.
- ONE:
  - in_fire & out_fire -> ONE, main<=in (zero-bubble streaming, 1 entry/cycle).
  - in_fire only -> FULL, skid<=in, main held.
  - out_fire only -> EMPTY.
  - neither -> hold.
- FULL:
  - in_ready=0.
  - out_fire -> ONE, main<=skid, skid_v<=0.
  - otherwise hold.
- Latency: in_fire in cycle N gives out_valid in cycle N+1 when the stage is EMPTY, or when it is ONE with out_fire in N. Order is strictly FIFO.
- Throughput: 1 entry/cycle sustained while out_ready=1.
- flush:
  - Highest priority, synchronous: main_v<=0, skid_v<=0, main_c<=0, skid_c<=0. main_d and skid_d are held.
  - An input beat in the same cycle is discarded. An out_fire in the same cycle still counts as consumed downstream.
  - Next state is EMPTY, with in_ready=1 in the next cycle.
- Reset (async, any time including mid-transfer): all valid bits 0, all data/ctrl registers 0. Outputs: out_valid=0, out_data=0, out_ctrl=0, in_ready=1.

Optional Feature:
PIPE_STAGE_STATS_EN
- Defined:
  - Adds outputs stall_cnt[31:0] and bubble_cnt[31:0].
  - stall_cnt increments each cycle with main_v=1 & out_ready=0.
  - bubble_cnt increments each cycle with main_v=0 & ~rst.
  - Both counters saturate at 32'hFFFFFFFF, clear only on rst (not on flush), and reset to 0.
- Undefined: ports and counters absent; core behaviour identical.

Test Plan:
1. Reset then idle: rst=1 mid-stream while FULL -> immediately out_valid=0, out_ctrl=0, out_data=0, in_ready=1; after release, 3 idle cycles with out_valid=0 (stats: bubble_cnt=3).
2. Streaming: out_ready=1, in_valid=1 for 8 cycles, in_data=1..8, in_ctrl=8'hA5 -> out_data 1..8 on consecutive cycles starting 1 cycle after the first accept, no gaps, out_ctrl=8'hA5.
3. Backpressure/skid: stream 1,2,3, drop out_ready low after out_data=1 shown -> entry 2 captured in skid, in_ready=0 next cycle, entry 3 held upstream; raise out_ready -> outputs 1,2,3 in order, none lost or duplicated (stats: stall_cnt equals number of low out_ready cycles with valid).
4. Flush in FULL: main=5 (ctrl 8'hFF), skid=6, assert flush with in_valid=1, in_data=7 -> next cycle out_valid=0, out_ctrl=0, in_ready=1; 7 never appears at output.
5. Flush with simultaneous out_fire: ONE holding 9, out_ready=1, flush=1 -> 9 consumed that cycle, stage EMPTY next cycle, no repeat of 9.
6. Random valid/ready (10k cycles, scoreboard) -> output sequence equals accepted input sequence; skid_v=1 & main_v=0 never observed; in_ready never depends combinationally on out_ready.
